// File: rtl/sobel_seq_pkg.sv
// Shared types and default geometry for the Sobel frame sequencer.
package sobel_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        DRAIN
    } seq_state_t;

    localparam int ROW_LOOP_DEF = 3;
    localparam int DIMWIDTH_DEF = 16;

endpackage

// File: rtl/sobel_pos_counter.sv
// Column/row position of the current input beat within a frame.
// The frame geometry is captured on load so the config ports may change mid-frame.
module sobel_pos_counter
    import sobel_seq_pkg::*;
#(
    parameter int DIMWIDTH = DIMWIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                inc_i,
    input  logic [DIMWIDTH-1:0] width_i,
    input  logic [DIMWIDTH-1:0] height_i,
    output logic [DIMWIDTH-1:0] row_o,
    output logic                row_end_o,
    output logic                frame_end_o
);

    logic [DIMWIDTH-1:0] width_q, width_d;
    logic [DIMWIDTH-1:0] height_q, height_d;
    logic [DIMWIDTH-1:0] col_q, col_d;
    logic [DIMWIDTH-1:0] row_q, row_d;

    assign row_end_o   = (col_q == width_q - 1'b1);
    assign frame_end_o = row_end_o && (row_q == height_q - 1'b1);
    assign row_o       = row_q;

    // Rows never wrap: the sequencer leaves RUN on the frame-end beat.
    always_comb begin
        width_d  = width_q;
        height_d = height_q;
        col_d    = col_q;
        row_d    = row_q;
        if (load_i) begin
            width_d  = width_i;
            height_d = height_i;
            col_d    = '0;
            row_d    = '0;
        end else if (inc_i) begin
            if (row_end_o) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            width_q  <= '0;
            height_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            width_q  <= width_d;
            height_q <= height_d;
            col_q    <= col_d;
            row_q    <= row_d;
        end
    end

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Frame controller for the Sobel pipeline: counts beats, tags window beats,
// suppresses results while line buffers prime, then waits for the output stage to drain.
module sobel_frame_sequencer
    import sobel_seq_pkg::*;
#(
    parameter int PIXEL         = 3,
    parameter int ROW_LOOP      = ROW_LOOP_DEF,
    parameter int DIMWIDTH      = DIMWIDTH_DEF,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                ARESET,
    input  logic [DIMWIDTH-1:0] cfg_width,
    input  logic [DIMWIDTH-1:0] cfg_height,
    input  logic                start,
    output logic                active,
    output logic                done,
    output logic                err,
    input  logic                s_strobe,
    output logic                s_busy,
    output logic                win_strobe,
    input  logic                win_busy,
    output logic                win_emit,
    output logic                win_tlast,
    output logic                lb_rotate,
    input  logic                mon_strobe,
    input  logic                mon_busy,
    input  logic                mon_tlast
);

    localparam int DCW = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [DCW-1:0]      DRAIN_LAST     = DCW'(DRAIN_TIMEOUT - 1);
    localparam logic [DIMWIDTH-1:0] PRIME_LAST_ROW = DIMWIDTH'(ROW_LOOP - 2);
    localparam logic [DIMWIDTH-1:0] MIN_HEIGHT     = DIMWIDTH'(ROW_LOOP);

    // Beats, not pixels, are the counted unit; nothing elaborates for legal parameters.
    if (PIXEL < 1 || ROW_LOOP < 2) begin : g_param_guard
    end

    seq_state_t          state_q, state_d;
    logic                active_q, active_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DCW-1:0]      drain_cnt_q, drain_cnt_d;
    logic                win_strobe_q, win_strobe_d;
    logic                win_emit_q, win_emit_d;
    logic                win_tlast_q, win_tlast_d;
    logic                lb_rotate_q, lb_rotate_d;

    logic                xfer;
    logic                cnt_load;
    logic                cfg_bad;
    logic                row_end;
    logic                frame_end;
    logic [DIMWIDTH-1:0] row;

    assign s_busy  = !(state_q == PRIME || state_q == RUN) || (win_strobe_q && win_busy);
    assign xfer    = s_strobe && !s_busy;
    assign cfg_bad = (cfg_width == '0) || (cfg_height < MIN_HEIGHT);

    sobel_pos_counter #(
        .DIMWIDTH(DIMWIDTH)
    ) u_pos (
        .clk        (clk),
        .rst_i      (ARESET),
        .load_i     (cnt_load),
        .inc_i      (xfer),
        .width_i    (cfg_width),
        .height_i   (cfg_height),
        .row_o      (row),
        .row_end_o  (row_end),
        .frame_end_o(frame_end)
    );

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        drain_cnt_d = drain_cnt_q;
        cnt_load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        active_d = 1'b1;
                        state_d  = PRIME;
                    end
                end
            end
            PRIME: begin
                if (xfer && row_end && row == PRIME_LAST_ROW) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (xfer && frame_end) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                // A drain completion wins over a timeout landing on the same cycle.
                if (mon_strobe && !mon_busy && mon_tlast) begin
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Window beat register: load on transfer, hold while stalled, clear once taken.
    always_comb begin
        win_strobe_d = win_strobe_q;
        win_emit_d   = win_emit_q;
        win_tlast_d  = win_tlast_q;
        lb_rotate_d  = lb_rotate_q;
        if (xfer) begin
            win_strobe_d = 1'b1;
            lb_rotate_d  = row_end;
            win_emit_d   = (state_q == RUN);
            win_tlast_d  = frame_end;
        end else if (!win_busy) begin
            win_strobe_d = 1'b0;
            lb_rotate_d  = 1'b0;
            win_emit_d   = 1'b0;
            win_tlast_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= IDLE;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            drain_cnt_q  <= '0;
            win_strobe_q <= 1'b0;
            win_emit_q   <= 1'b0;
            win_tlast_q  <= 1'b0;
            lb_rotate_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            done_q       <= done_d;
            err_q        <= err_d;
            drain_cnt_q  <= drain_cnt_d;
            win_strobe_q <= win_strobe_d;
            win_emit_q   <= win_emit_d;
            win_tlast_q  <= win_tlast_d;
            lb_rotate_q  <= lb_rotate_d;
        end
    end

    assign active     = active_q;
    assign done       = done_q;
    assign err        = err_q;
    assign win_strobe = win_strobe_q;
    assign win_emit   = win_emit_q;
    assign win_tlast  = win_tlast_q;
    assign lb_rotate  = lb_rotate_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Directed and randomized frames against a beat-number reference model of the sequencer.
module tb_sobel_frame_sequencer;

    localparam int DW       = 16;
    localparam int ROW_LOOP = 3;
    localparam int TIMEOUT  = 16;

    logic          clk;
    logic          ARESET;
    logic [DW-1:0] cfg_width, cfg_height;
    logic          start, active, done, err;
    logic          s_strobe, s_busy;
    logic          win_strobe, win_busy, win_emit, win_tlast, lb_rotate;
    logic          mon_strobe, mon_busy, mon_tlast;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor-owned history: accepted window beats {rotate, emit, tlast}, transfers, pulses.
    logic [2:0] acc_q[$];
    int xfer_cnt = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    sobel_frame_sequencer #(
        .PIXEL(3), .ROW_LOOP(ROW_LOOP), .DIMWIDTH(DW), .DRAIN_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .ARESET(ARESET), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .start(start), .active(active), .done(done), .err(err),
        .s_strobe(s_strobe), .s_busy(s_busy),
        .win_strobe(win_strobe), .win_busy(win_busy), .win_emit(win_emit),
        .win_tlast(win_tlast), .lb_rotate(lb_rotate),
        .mon_strobe(mon_strobe), .mon_busy(mon_busy), .mon_tlast(mon_tlast)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (!ARESET) begin
            if (win_strobe && !win_busy) acc_q.push_back({lb_rotate, win_emit, win_tlast});
            if (s_strobe && !s_busy) xfer_cnt++;
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: tags of the n-th beat (1-based) of a W x H frame.
    function automatic logic [2:0] model_tags(input int n, input int w, input int h);
        logic rot, emit, last;
        rot  = (n % w) == 0;
        emit = n > (ROW_LOOP - 1) * w;
        last = n == w * h;
        return {rot, emit, last};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_active"},     active,     0);
        check({tag, "_done"},       done,       0);
        check({tag, "_err"},        err,        0);
        check({tag, "_win_strobe"}, win_strobe, 0);
        check({tag, "_win_emit"},   win_emit,   0);
        check({tag, "_win_tlast"},  win_tlast,  0);
        check({tag, "_lb_rotate"},  lb_rotate,  0);
        check({tag, "_s_busy"},     s_busy,     1);
    endtask

    // mon_delay < 0: never complete the drain and expect the timeout instead.
    task automatic run_frame(input int w, input int h, input int gaps, input int busy_pct,
                             input int hold_at, input int start_at, input int mon_delay);
        int xb, ab, db, eb, cyc, k;
        bit held, pulsed;
        logic [2:0] cap;
        xb = xfer_cnt; ab = acc_q.size(); db = done_cnt; eb = err_cnt;
        held = 0; pulsed = 0;
        cfg_width = DW'(w); cfg_height = DW'(h); start = 1'b1;
        step();
        start = 1'b0;
        check("active_at_start", active, 1);
        cyc = 0;
        while (xfer_cnt - xb < w * h && cyc < 4000) begin
            if (hold_at > 0 && !held && acc_q.size() - ab == hold_at - 1 && win_strobe) begin
                held = 1;
                cap = {lb_rotate, win_emit, win_tlast};
                check("hold_beat_tags", cap, model_tags(hold_at, w, h));
                win_busy = 1'b1; s_strobe = 1'b1;
                repeat (3) begin
                    step(); cyc++;
                    check("hold_strobe", win_strobe, 1);
                    check("hold_tags", {lb_rotate, win_emit, win_tlast}, cap);
                    check("hold_s_busy", s_busy, 1);
                end
            end
            s_strobe = (gaps != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            win_busy = (busy_pct != 0) && ($urandom_range(0, 99) < busy_pct);
            if (start_at > 0 && !pulsed && xfer_cnt - xb == start_at) begin
                pulsed = 1; start = 1'b1; cfg_width = '0; cfg_height = DW'(1);
            end
            step(); cyc++;
            start = 1'b0; cfg_width = DW'(w); cfg_height = DW'(h);
        end
        s_strobe = 1'b0; win_busy = 1'b0;
        check("s_busy_after_last", s_busy, 1);
        if (mon_delay < 0) begin
            k = 0;
            while (err !== 1'b1 && k < 40) begin step(); k++; end
            check("timeout_cycles", k, TIMEOUT);
            check("timeout_active", active, 0);
            check("timeout_done", done, 0);
            check("timeout_s_busy", s_busy, 1);
            step();
            check("err_one_cycle", err, 0);
            check("timeout_err_pulses", err_cnt - eb, 1);
            check("timeout_done_pulses", done_cnt - db, 0);
        end else begin
            repeat (mon_delay) step();
            mon_strobe = 1'b1; mon_tlast = 1'b1;
            if (mon_delay < 14) begin
                mon_busy = 1'b1;
                step();
                check("done_blocked_by_mon_busy", done, 0);
                check("active_in_drain", active, 1);
            end
            mon_busy = 1'b0;
            step();
            check("done_pulse", done, 1);
            check("err_with_done", err, 0);
            check("active_after_done", active, 0);
            mon_strobe = 1'b0; mon_tlast = 1'b0;
            step();
            check("done_one_cycle", done, 0);
            check("done_pulses", done_cnt - db, 1);
            check("err_pulses", err_cnt - eb, 0);
        end
        check("beat_count", acc_q.size() - ab, w * h);
        for (int i = 0; i < acc_q.size() - ab && i < w * h; i++) begin
            check($sformatf("beat%0d_tags", i + 1), acc_q[ab + i], model_tags(i + 1, w, h));
        end
        $display("[TB] frame W=%0d H=%0d beats=%0d done=%0d err=%0d", w, h,
                 acc_q.size() - ab, done_cnt - db, err_cnt - eb);
    endtask

    initial begin
        int xb, cyc, w, h;
        ARESET = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
        s_strobe = 1'b0; win_busy = 1'b0;
        mon_strobe = 1'b0; mon_busy = 1'b0; mon_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        ARESET = 1'b0;
        step();
        check_idle("post_reset");

        run_frame(4, 5, 0, 0, 0, 0, 3);
        run_frame(4, 5, 0, 0, 10, 0, 2);

        cfg_width = DW'(4); cfg_height = DW'(2); start = 1'b1;
        step();
        start = 1'b0;
        check("bad_height_err", err, 1);
        check("bad_height_active", active, 0);
        check("bad_height_s_busy", s_busy, 1);
        step();
        check("bad_height_err_clear", err, 0);
        $display("[TB] bad config W=4 H=2 rejected");
        cfg_width = '0; cfg_height = DW'(5); start = 1'b1;
        step();
        start = 1'b0;
        check("bad_width_err", err, 1);
        check("bad_width_active", active, 0);
        check("bad_width_s_busy", s_busy, 1);
        step();
        check("bad_width_err_clear", err, 0);
        $display("[TB] bad config W=0 H=5 rejected");

        run_frame(2, 6, 0, 0, 0, 6, 1);

        for (int f = 0; f < 3; f++) begin
            w = int'($urandom_range(1, 6));
            h = int'($urandom_range(3, 6));
            run_frame(w, h, 1, 30, 0, 0, int'($urandom_range(0, 8)));
        end

        xb = xfer_cnt;
        cfg_width = DW'(4); cfg_height = DW'(5); start = 1'b1;
        step();
        start = 1'b0; s_strobe = 1'b1; cyc = 0;
        while (xfer_cnt - xb < 10 && cyc < 100) begin step(); cyc++; end
        s_strobe = 1'b0;
        check("pre_reset_strobe", win_strobe, 1);
        check("pre_reset_emit", win_emit, 1);
        #2 ARESET = 1'b1;
        #1;
        check_idle("async_reset");
        #1 ARESET = 1'b0;
        step();
        check_idle("after_async_reset");
        $display("[TB] frame W=4 H=5 abandoned by reset at beat 10");
        run_frame(2, 3, 0, 0, 0, 0, 2);

        run_frame(2, 3, 1, 20, 0, 0, -1);
        run_frame(1, 3, 0, 0, 0, 0, TIMEOUT - 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
